// File: rtl/jet_class_argmax.sv
// Sequential argmax over one captured vector of NCLASS signed logits, one compare per cycle.
// Optional second-best tracking and top1-top2 margin output: define JET_ARGMAX_MARGIN_EN.
module jet_class_argmax #(
   parameter int WIDTH  = 27,
   parameter int NCLASS = 5,
   parameter int IDXW   = $clog2(NCLASS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NCLASS*WIDTH-1:0]  logits_i,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDXW-1:0]          class_o,
   output logic [WIDTH-1:0]         max_o,
`ifdef JET_ARGMAX_MARGIN_EN
   output logic [WIDTH:0]           margin_o,
`endif
   output logic [1:0]               dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready and out_valid decode the state register only, so there is no input-to-output path.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                r_state;
   logic signed [WIDTH-1:0]   r_logit [NCLASS];
   logic signed [WIDTH-1:0]   r_best;
   logic [IDXW-1:0]           r_best_idx;
   logic [IDXW-1:0]           r_cnt;
   logic [IDXW-1:0]           r_class;
   logic [WIDTH-1:0]          r_max;

   logic signed [WIDTH-1:0]   w_cur;
   logic                      w_gt;
   logic                      w_last;
   logic signed [WIDTH-1:0]   w_nxt_best;
   logic [IDXW-1:0]           w_nxt_idx;

   always_comb begin
      w_cur      = r_logit[r_cnt];
      w_gt       = (w_cur > r_best);
      w_last     = (r_cnt == IDXW'(NCLASS - 1));
      w_nxt_best = w_gt ? w_cur : r_best;
      w_nxt_idx  = w_gt ? r_cnt : r_best_idx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_best     <= '0;
         r_best_idx <= '0;
         r_cnt      <= '0;
         r_class    <= '0;
         r_max      <= '0;
         for (int k = 0; k < NCLASS; k++) begin
            r_logit[k] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  for (int k = 0; k < NCLASS; k++) begin
                     r_logit[k] <= logits_i[k*WIDTH +: WIDTH];
                  end
                  r_best     <= logits_i[WIDTH-1:0];
                  r_best_idx <= '0;
                  r_cnt      <= IDXW'(1);
                  r_state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // Strictly-greater replace keeps the lowest index on ties.
               r_best     <= w_nxt_best;
               r_best_idx <= w_nxt_idx;
               if (w_last) begin
                  r_class <= w_nxt_idx;
                  r_max   <= w_nxt_best;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + IDXW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef JET_ARGMAX_MARGIN_EN
   logic signed [WIDTH-1:0]   r_second;
   logic [WIDTH:0]            r_margin;
   logic signed [WIDTH-1:0]   w_nxt_second;
   logic signed [WIDTH:0]     w_margin;

   // A demoted best becomes second; otherwise a logit that beats second (tie with best included) takes it.
   always_comb begin
      if (w_gt) begin
         w_nxt_second = r_best;
      end else if (w_cur > r_second) begin
         w_nxt_second = w_cur;
      end else begin
         w_nxt_second = r_second;
      end
      w_margin = {w_nxt_best[WIDTH-1], w_nxt_best} - {w_nxt_second[WIDTH-1], w_nxt_second};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_second <= '0;
         r_margin <= '0;
      end else begin
         if (r_state == ST_IDLE && in_valid) begin
            r_second <= {1'b1, {(WIDTH-1){1'b0}}};
         end else if (r_state == ST_SCAN) begin
            r_second <= w_nxt_second;
            if (w_last) begin
               r_margin <= w_margin;
            end
         end
      end
   end

   assign margin_o = r_margin;
`endif

   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = (r_state == ST_DONE);
   assign class_o     = r_class;
   assign max_o       = r_max;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_jet_class_argmax.sv
// Directed and random stimulus for jet_class_argmax with an expected-result queue and a monitor.
module tb_jet_class_argmax;

   localparam int WIDTH  = 27;
   localparam int NCLASS = 5;
   localparam int IDXW   = $clog2(NCLASS);
   localparam int EW     = IDXW + WIDTH + WIDTH + 1;
   localparam int VW     = NCLASS * WIDTH;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [VW-1:0]     logits_i = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [IDXW-1:0]   class_o;
   logic [WIDTH-1:0]  max_o;
   logic [WIDTH:0]    margin_w;
   logic [1:0]        dbg_state_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;
   bit chk_lat = 1'b0;
   logic [EW-1:0] exp_q[$];

   jet_class_argmax #(.WIDTH(WIDTH), .NCLASS(NCLASS)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .logits_i    (logits_i),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .class_o     (class_o),
      .max_o       (max_o),
`ifdef JET_ARGMAX_MARGIN_EN
      .margin_o    (margin_w),
`endif
      .dbg_state_o (dbg_state_o)
   );

`ifndef JET_ARGMAX_MARGIN_EN
   assign margin_w = '0;
`endif

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [VW-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
      int vals[5];
      logic [VW-1:0] v;
      vals = '{a, b, c, d, e};
      v = '0;
      for (int k = 0; k < 5; k++) v[k*WIDTH +: WIDTH] = vals[k][WIDTH-1:0];
      return v;
   endfunction

   function automatic logic [EW-1:0] mk_exp(input int idx, input int mx, input int mg);
      logic [IDXW-1:0]  ei;
      logic [WIDTH-1:0] em;
      logic [WIDTH:0]   eg;
      ei = idx[IDXW-1:0];
      em = mx[WIDTH-1:0];
      eg = mg[WIDTH:0];
      return {ei, em, eg};
   endfunction

   // Reference: first pass finds the lowest-index maximum, second pass the best of the rest.
   function automatic logic [EW-1:0] ref_model(input logic [VW-1:0] v);
      logic signed [WIDTH-1:0] x, mx, sec;
      logic signed [WIDTH:0]   mg;
      int idx;
      idx = 0;
      mx  = v[WIDTH-1:0];
      for (int k = 1; k < NCLASS; k++) begin
         x = v[k*WIDTH +: WIDTH];
         if (x > mx) begin mx = x; idx = k; end
      end
      sec = {1'b1, {(WIDTH-1){1'b0}}};
      for (int k = 0; k < NCLASS; k++) begin
         x = v[k*WIDTH +: WIDTH];
         if (k != idx && x > sec) sec = x;
      end
      mg = {mx[WIDTH-1], mx} - {sec[WIDTH-1], sec};
      return {idx[IDXW-1:0], mx, mg};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // driver: present a vector, wait for in_ready, optionally push its expected result
   task automatic send_vec(input logic [VW-1:0] v, input logic [EW-1:0] e, input bit push, output int acc);
      int guard;
      guard = 0;
      acc = -1;
      in_valid = 1'b1;
      logits_i = v;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
      end else begin
         acc = cyc + 1;
         last_acc = acc;
         if (push) exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [EW-1:0] got, exp;
      if (reset_n && out_valid && out_ready) begin
         got = {class_o, max_o, margin_w};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got=%0h required=none", got);
         end else begin
            exp = exp_q.pop_front();
`ifndef JET_ARGMAX_MARGIN_EN
            exp[WIDTH:0] = '0;
`endif
            if (got !== exp) begin
               errors++;
               $display("FAIL result class/max/margin got=%0d/%0d/%0d required=%0d/%0d/%0d",
                        class_o, $signed(max_o), margin_w,
                        exp[EW-1 -: IDXW], $signed(exp[WIDTH+WIDTH:WIDTH+1]), exp[WIDTH:0]);
            end
         end
         if (chk_lat) begin
            checks++;
            if (cyc + 1 - last_acc != NCLASS) begin
               errors++;
               $display("FAIL latency got=%0d required=%0d", cyc + 1 - last_acc, NCLASS);
            end
         end
      end
   end

   initial begin
      int acc, prev;
      int guard;
      logic [VW-1:0] v;
      logic [VW-1:0] basic;
      logic [WIDTH-1:0] r;

      basic = pack5(-510, -514, -575, 672, 1766);

      // reset held
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_class", 64'(class_o), 64'd0);
      check("rst_max", 64'(max_o), 64'd0);
      check("rst_margin", 64'(margin_w), 64'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_in_ready", 64'(in_ready), 64'd1);
         check("idle_out_valid", 64'(out_valid), 64'd0);
         check("idle_outputs", 64'({class_o, max_o}), 64'd0);
      end

      // directed vectors, out_ready high, latency checked
      chk_lat = 1'b1;
      @(posedge clk); #1;
      send_vec(basic, mk_exp(4, 1766, 1094), 1'b1, acc);
      send_vec(pack5(-8, -3, -3, -100, -3), mk_exp(1, -3, 0), 1'b1, acc);
      send_vec(pack5(-67108864, -67108864, -67108864, -67108864, -67108864),
               mk_exp(0, -67108864, 0), 1'b1, acc);
      send_vec(pack5(67108863, -67108864, 0, 67108862, 1), mk_exp(0, 67108863, 1), 1'b1, acc);
      send_vec(pack5(-67108864, 7, 9, 9, 67108863), mk_exp(4, 67108863, 67108854), 1'b1, acc);

      // backpressure
      @(negedge clk);
      while (!in_ready) @(negedge clk);
      @(posedge clk); #1;
      chk_lat = 1'b0;
      out_ready = 1'b0;
      send_vec(basic, mk_exp(4, 1766, 1094), 1'b1, acc);
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
      in_valid = 1'b1;
      logits_i = pack5(9000, 1, 1, 1, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_hold", 64'({class_o, max_o}), 64'({3'd4, 27'd1766}));
         @(negedge clk);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);

      // reset two cycles into a scan
      send_vec(basic, '0, 1'b0, acc);
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("rstscan_out_valid", 64'(out_valid), 64'd0);
      check("rstscan_state", 64'(dbg_state_o), 64'd0);
      check("rstscan_outputs", 64'({class_o, max_o, margin_w}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rstscan_no_result", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;
      chk_lat = 1'b1;
      send_vec(pack5(5, 0, 0, 0, 0), mk_exp(0, 5, 5), 1'b1, acc);

      // back-to-back random vectors, small ranges on odd lanes to force ties
      prev = 0;
      for (int i = 0; i < 100; i++) begin
         v = '0;
         for (int k = 0; k < NCLASS; k++) begin
            if (k % 2 == 1 || i % 3 == 0) r = WIDTH'($urandom_range(0, 6)) - WIDTH'(3);
            else r = WIDTH'($urandom());
            v[k*WIDTH +: WIDTH] = r;
         end
         send_vec(v, ref_model(v), 1'b1, acc);
         if (i > 0) check("throughput", 64'(acc - prev), 64'(NCLASS + 1));
         prev = acc;
      end

      // drain
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin @(posedge clk); guard++; end
      repeat (2) @(posedge clk);
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
